psram_access_arbiter: RTL and testbench
=======================================

Name: psram_access_arbiter

Overview:
- Shares the external asynchronous PSRAM between two fabric requesters: the capture write path (cap) and the MSS fabric bridge (mss, read/write).
- Grants one requester at a time with fair round-robin and sequences the PSRAM pins through setup, strobe and hold phases.
- Sits between the capture/MSS logic and the top-level psram_* pads; the top level builds the tri-state data buffer from psram_dout/psram_doe.

Parameters:
ADDR_W, 25, requester byte-pair address width; MSB selects chip (0→ncs0, 1→ncs1)
SETUP_CYC, 1, cycles with address/CS valid before strobe (≥1)
STROBE_CYC, 3, cycles nwe/noe held low (≥1)
HOLD_CYC, 1, cycles after strobe release with CS/address/data held (≥1)

Ports:
CLK50  in  1  system clock
RESET  in  1  synchronous, active-high reset
cap_req  in  1  capture write request, held until cap_ack
cap_addr  in  ADDR_W  capture address
cap_wdata  in  16  capture write data
cap_be  in  2  capture byte enables, active-high
cap_ack  out  1  one-cycle completion pulse
mss_req  in  1  MSS request, held until mss_ack
mss_we  in  1  1 = write, 0 = read
mss_addr  in  ADDR_W  MSS address
mss_wdata  in  16  MSS write data
mss_be  in  2  MSS byte enables, active-high
mss_rdata  out  16  read data, registered
mss_ack  out  1  one-cycle completion pulse
psram_address  out  ADDR_W-1  PSRAM address (chip-select bit stripped)
psram_ncs0  out  1  chip 0 select, active-low
psram_ncs1  out  1  chip 1 select, active-low
psram_nwe  out  1  write strobe, active-low
psram_noe0  out  1  chip 0 output enable, active-low
psram_noe1  out  1  chip 1 output enable, active-low
psram_nbyte_en  out  2  byte enables, active-low (~be)
psram_dout  out  16  write data to pad
psram_doe  out  1  pad output enable
psram_din  in  16  data from pad

Behaviour:
- All outputs registered. Reset: ncs0/ncs1/nwe/noe0/noe1 = 1, nbyte_en = 2'b11, doe = 0, dout = 0, address = 0, rdata = 0, acks = 0, state IDLE, last_grant = MSS (capture wins first contention).
- FSM: IDLE → SETUP → STROBE → HOLD → IDLE. One down-counter is loaded with phase length-1 on each phase entry.
- IDLE: at most one grant per cycle. Only one req → grant it. Both → grant the requester ≠ last_grant. On grant, latch addr/wdata/be/we (cap always write) and update last_grant.
- SETUP: address, nbyte_en and selected ncs low. For writes, doe = 1 and dout = wdata. Strobes high.
- STROBE: nwe low (write) or selected noe low (read). psram_din is captured into mss_rdata on the last STROBE cycle.
- HOLD: strobes high; ncs, address, dout and doe unchanged. Owner ack = 1 in the last HOLD cycle only. After the following edge: ncs high, doe = 0, state IDLE.
- Latency: req seen in IDLE at cycle 0 → ack at cycle SETUP_CYC+STROBE_CYC+HOLD_CYC (5 with defaults); next grant at cycle 6. Back-to-back throughput is 1 access per 6 cycles.
- The requester drops or updates req on the edge ending its ack cycle. IDLE samples fresh req, so there is no double-grant.
- Request inputs that change after grant are ignored (latched copy is used).
- ncs0 and ncs1 are never low together. nwe and noe are never low together. doe = 1 only in SETUP/STROBE/HOLD of writes.
- mss_rdata is held until the next MSS read completes; cap transactions never change it.
- Synchronous RESET mid-access: all strobes and CS go high on the next edge, doe = 0, no ack is issued, and the pending access is dropped.

Decomposition:
- Shared package: FSM state encoding (IDLE/SETUP/STROBE/HOLD), requester ID constants (REQ_CAP, REQ_MSS), data width constant 16.
- No sub-module needed; optionally a psram_rr_arb two-requester round-robin unit, otherwise inline.

Test Plan:
- Single cap write, addr 0x0000123, data 0xBEEF, be 2'b11 → ncs0 low cycles 1–5; nwe low cycles 2–4; doe = 1 and dout = 0xBEEF throughout; nbyte_en = 00; cap_ack at cycle 5 only.
- MSS read, addr 0x1000040 (chip 1), model drives din = 0x5A5A → ncs1 and noe1 low; ncs0/noe0 stay high; mss_rdata = 0x5A5A from cycle 5; doe = 0 throughout.
- cap_req and mss_req both held for 4 accesses from reset → grant order cap, mss, cap, mss; acks at cycles 5, 11, 17, 23.
- MSS write, be = 2'b10 → nbyte_en = 2'b01 during access; cap_ack never asserts.
- RESET asserted during STROBE of a write → next cycle nwe/ncs0 = 1 and doe = 0; no ack; the first access after release behaves as a fresh access.
- SETUP_CYC=2, STROBE_CYC=4, HOLD_CYC=2 → ack at cycle 8; nwe low for exactly 4 cycles.

Source files
------------

// File: rtl/psram_access_arbiter_pkg.sv
// psram_access_arbiter_pkg: shared FSM states, requester IDs and data width for the PSRAM arbiter
package psram_access_arbiter_pkg;
   localparam int DATA_W = 16;
   localparam logic REQ_CAP = 1'b0;
   localparam logic REQ_MSS = 1'b1;
   typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;
endpackage

// File: rtl/psram_access_arbiter.sv
// psram_access_arbiter: round-robin sharing of the async PSRAM between capture writes and MSS accesses
module psram_access_arbiter
   import psram_access_arbiter_pkg::*;
#(
   parameter int ADDR_W = 25,
   parameter int SETUP_CYC = 1,
   parameter int STROBE_CYC = 3,
   parameter int HOLD_CYC = 1
) (
   input  logic              CLK50,
   input  logic              RESET,
   input  logic              cap_req,
   input  logic [ADDR_W-1:0] cap_addr,
   input  logic [DATA_W-1:0] cap_wdata,
   input  logic [1:0]        cap_be,
   output logic              cap_ack,
   input  logic              mss_req,
   input  logic              mss_we,
   input  logic [ADDR_W-1:0] mss_addr,
   input  logic [DATA_W-1:0] mss_wdata,
   input  logic [1:0]        mss_be,
   output logic [DATA_W-1:0] mss_rdata,
   output logic              mss_ack,
   output logic [ADDR_W-2:0] psram_address,
   output logic              psram_ncs0,
   output logic              psram_ncs1,
   output logic              psram_nwe,
   output logic              psram_noe0,
   output logic              psram_noe1,
   output logic [1:0]        psram_nbyte_en,
   output logic [DATA_W-1:0] psram_dout,
   output logic              psram_doe,
   input  logic [DATA_W-1:0] psram_din
);
   state_t state, state_n;
   logic [7:0] cnt, cnt_n;
   logic own, own_n, we, we_n, pick, act, chip1, stb;
   logic [ADDR_W-1:0] addr, addr_n;
   logic [DATA_W-1:0] wdata, wdata_n;
   logic [1:0] be, be_n;
   // own doubles as last_grant: it only changes when a new grant is made
   always_comb begin
      pick = (cap_req && mss_req) ? ((own == REQ_CAP) ? REQ_MSS : REQ_CAP) : (mss_req ? REQ_MSS : REQ_CAP);
      state_n = state;
      cnt_n = (state == IDLE) ? cnt : cnt - 8'd1;
      own_n = own;
      we_n = we;
      addr_n = addr;
      wdata_n = wdata;
      be_n = be;
      if (state == IDLE && (cap_req || mss_req)) begin
         state_n = SETUP;
         cnt_n = 8'(SETUP_CYC - 1);
         own_n = pick;
         we_n = (pick == REQ_CAP) || mss_we;
         addr_n = (pick == REQ_CAP) ? cap_addr : mss_addr;
         wdata_n = (pick == REQ_CAP) ? cap_wdata : mss_wdata;
         be_n = (pick == REQ_CAP) ? cap_be : mss_be;
      end else if (state != IDLE && cnt == '0) begin
         state_n = (state == SETUP) ? STROBE : (state == STROBE) ? HOLD : IDLE;
         cnt_n = (state == SETUP) ? 8'(STROBE_CYC - 1) : 8'(HOLD_CYC - 1);
      end
      act = state_n != IDLE;
      chip1 = addr_n[ADDR_W-1];
      stb = state_n == STROBE;
   end
   // pin values are computed from the next state so every output comes straight from a flop
   always_ff @(posedge CLK50) begin
      if (RESET) begin
         state <= IDLE;
         cnt <= '0;
         own <= REQ_MSS;
         we <= 1'b0;
         addr <= '0;
         wdata <= '0;
         be <= '0;
         psram_ncs0 <= 1'b1;
         psram_ncs1 <= 1'b1;
         psram_nwe <= 1'b1;
         psram_noe0 <= 1'b1;
         psram_noe1 <= 1'b1;
         psram_nbyte_en <= 2'b11;
         psram_doe <= 1'b0;
         psram_dout <= '0;
         psram_address <= '0;
         mss_rdata <= '0;
         cap_ack <= 1'b0;
         mss_ack <= 1'b0;
      end else begin
         state <= state_n;
         cnt <= cnt_n;
         own <= own_n;
         we <= we_n;
         addr <= addr_n;
         wdata <= wdata_n;
         be <= be_n;
         psram_ncs0 <= !(act && !chip1);
         psram_ncs1 <= !(act && chip1);
         psram_nwe <= !(stb && we_n);
         psram_noe0 <= !(stb && !we_n && !chip1);
         psram_noe1 <= !(stb && !we_n && chip1);
         psram_nbyte_en <= act ? ~be_n : 2'b11;
         psram_doe <= act && we_n;
         if (act) psram_address <= addr_n[ADDR_W-2:0];
         if (act && we_n) psram_dout <= wdata_n;
         cap_ack <= state_n == HOLD && cnt_n == '0 && own_n == REQ_CAP;
         mss_ack <= state_n == HOLD && cnt_n == '0 && own_n == REQ_MSS;
         if (state == STROBE && cnt == '0 && !we) mss_rdata <= psram_din;
      end
   end
endmodule

// File: tb/tb_psram_access_arbiter.sv
// tb_psram_access_arbiter: timeline model compared every cycle, plus directed literal checks
module tb_psram_access_arbiter;
   localparam int AW = 25, S = 1, T = 3, H = 1;
   localparam logic CAP = 1'b0, MSS = 1'b1;
   logic clk = 1'b0, rst = 1'b1;
   always #5 clk = ~clk;
   int cyc = 0, checks = 0, errors = 0;
   always @(posedge clk) cyc <= cyc + 1;
   logic cap_req = 0, mss_req = 0, mss_we = 0, c2_req = 0;
   logic [AW-1:0] cap_addr = '0, mss_addr = '0;
   logic [15:0] cap_wdata = '0, mss_wdata = '0, din = '0;
   logic [1:0] cap_be = '0, mss_be = '0;
   logic cap_ack, mss_ack, ncs0, ncs1, nwe, noe0, noe1, doe;
   logic [15:0] mss_rdata, dout;
   logic [1:0] nbe;
   logic [AW-2:0] paddr;
   logic cap_ack2, mss_ack2, ncs0_2, ncs1_2, nwe2, noe0_2, noe1_2, doe2;
   logic [15:0] mss_rdata2, dout2;
   logic [1:0] nbe2;
   logic [AW-2:0] paddr2;
   psram_access_arbiter dut (
      .CLK50(clk), .RESET(rst),
      .cap_req(cap_req), .cap_addr(cap_addr), .cap_wdata(cap_wdata), .cap_be(cap_be), .cap_ack(cap_ack),
      .mss_req(mss_req), .mss_we(mss_we), .mss_addr(mss_addr), .mss_wdata(mss_wdata), .mss_be(mss_be),
      .mss_rdata(mss_rdata), .mss_ack(mss_ack),
      .psram_address(paddr), .psram_ncs0(ncs0), .psram_ncs1(ncs1), .psram_nwe(nwe),
      .psram_noe0(noe0), .psram_noe1(noe1), .psram_nbyte_en(nbe), .psram_dout(dout),
      .psram_doe(doe), .psram_din(din));
   psram_access_arbiter #(.ADDR_W(AW), .SETUP_CYC(2), .STROBE_CYC(4), .HOLD_CYC(2)) dut2 (
      .CLK50(clk), .RESET(rst),
      .cap_req(c2_req), .cap_addr(cap_addr), .cap_wdata(cap_wdata), .cap_be(cap_be), .cap_ack(cap_ack2),
      .mss_req(1'b0), .mss_we(1'b0), .mss_addr('0), .mss_wdata('0), .mss_be(2'b00),
      .mss_rdata(mss_rdata2), .mss_ack(mss_ack2),
      .psram_address(paddr2), .psram_ncs0(ncs0_2), .psram_ncs1(ncs1_2), .psram_nwe(nwe2),
      .psram_noe0(noe0_2), .psram_noe1(noe1_2), .psram_nbyte_en(nbe2), .psram_dout(dout2),
      .psram_doe(doe2), .psram_din(din));

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // model: m_k is the position of the coming cycle inside the access (1..S+T+H)
   logic m_busy = 0, m_own = MSS, m_last = MSS, m_we = 0;
   int m_k = 0;
   logic [AW-1:0] m_addr = '0;
   logic [15:0] m_wdata = '0, e_rdata = '0, e_dout = '0;
   logic [1:0] m_be = '0, e_nbe = 2'b11;
   logic [AW-2:0] e_addr = '0;
   logic e_ncs0 = 1, e_ncs1 = 1, e_nwe = 1, e_noe0 = 1, e_noe1 = 1, e_doe = 0, e_cap_ack = 0, e_mss_ack = 0;
   task automatic model_step();
      logic strobe, hi;
      if (rst) begin
         m_busy = 0; m_last = MSS; e_rdata = '0; e_dout = '0; e_addr = '0;
      end else begin
         if (m_busy && !m_we && m_k == S + T) e_rdata = din;
         if (m_busy) begin
            if (m_k == S + T + H) m_busy = 0;
            else m_k++;
         end else if (cap_req || mss_req) begin
            m_own = (cap_req && (!mss_req || m_last == MSS)) ? CAP : MSS;
            m_last = m_own;
            m_busy = 1;
            m_k = 1;
            if (m_own == CAP) begin m_we = 1; m_addr = cap_addr; m_wdata = cap_wdata; m_be = cap_be; end
            else begin m_we = mss_we; m_addr = mss_addr; m_wdata = mss_wdata; m_be = mss_be; end
         end
      end
      strobe = m_busy && m_k > S && m_k <= S + T;
      hi = m_addr[AW-1];
      e_ncs0 = !(m_busy && !hi);
      e_ncs1 = !(m_busy && hi);
      e_nwe = !(strobe && m_we);
      e_noe0 = !(strobe && !m_we && !hi);
      e_noe1 = !(strobe && !m_we && hi);
      e_nbe = m_busy ? ~m_be : 2'b11;
      e_doe = m_busy && m_we;
      if (m_busy) e_addr = m_addr[AW-2:0];
      if (m_busy && m_we) e_dout = m_wdata;
      e_cap_ack = m_busy && m_k == S + T + H && m_own == CAP;
      e_mss_ack = m_busy && m_k == S + T + H && m_own == MSS;
   endtask
   always @(posedge clk) model_step();

   always @(negedge clk) begin
      chk("ncs0", ncs0, e_ncs0);
      chk("ncs1", ncs1, e_ncs1);
      chk("nwe", nwe, e_nwe);
      chk("noe0", noe0, e_noe0);
      chk("noe1", noe1, e_noe1);
      chk("nbyte_en", nbe, e_nbe);
      chk("doe", doe, e_doe);
      chk("dout", dout, e_dout);
      chk("address", paddr, e_addr);
      chk("cap_ack", cap_ack, e_cap_ack);
      chk("mss_ack", mss_ack, e_mss_ack);
      chk("mss_rdata", mss_rdata, e_rdata);
   end

   int r_ack, r_cs0, r_cs1, r_nwe, r_noe0, r_noe1, r_doe, r_other;
   logic [15:0] r_dout, r_rdata;
   logic [1:0] r_nbe;
   task automatic run1(input logic who, input logic we, input logic [AW-1:0] a, input logic [15:0] d, input logic [1:0] be);
      r_ack = -1; r_cs0 = 0; r_cs1 = 0; r_nwe = 0; r_noe0 = 0; r_noe1 = 0; r_doe = 0; r_other = 0;
      r_dout = '0; r_rdata = '0; r_nbe = 2'b11;
      if (who == CAP) begin cap_addr = a; cap_wdata = d; cap_be = be; cap_req = 1; end
      else begin mss_we = we; mss_addr = a; mss_wdata = d; mss_be = be; mss_req = 1; end
      for (int k = 1; k <= 40 && r_ack < 0; k++) begin
         @(negedge clk);
         r_cs0 += ncs0 ? 0 : 1;
         r_cs1 += ncs1 ? 0 : 1;
         r_nwe += nwe ? 0 : 1;
         r_noe0 += noe0 ? 0 : 1;
         r_noe1 += noe1 ? 0 : 1;
         r_doe += doe ? 1 : 0;
         if (!ncs0 || !ncs1) r_nbe = nbe;
         if (doe) r_dout = dout;
         r_rdata = mss_rdata;
         if (who == CAP ? cap_ack : mss_ack) r_ack = k;
         else if (who == CAP ? mss_ack : cap_ack) r_other++;
      end
      cap_req = 0;
      mss_req = 0;
   endtask

   int cap_acks[$], mss_acks[$];
   task automatic cap_seq(input int n, input int t0);
      int w;
      for (int i = 0; i < n; i++) begin
         cap_addr = 25'h0000400 + AW'(i); cap_wdata = 16'h1100 + 16'(i); cap_be = 2'b11; cap_req = 1;
         for (w = 0; w < 40; w++) begin @(negedge clk); if (cap_ack) break; end
         cap_acks.push_back(w < 40 ? cyc - t0 : -1);
      end
      cap_req = 0;
   endtask
   task automatic mss_seq(input int n, input int t0);
      int w;
      for (int i = 0; i < n; i++) begin
         mss_we = (i % 2) == 0; mss_addr = 25'h1000800 + AW'(i); mss_wdata = 16'h2200 + 16'(i); mss_be = 2'b01; mss_req = 1;
         for (w = 0; w < 40; w++) begin @(negedge clk); if (mss_ack) break; end
         mss_acks.push_back(w < 40 ? cyc - t0 : -1);
      end
      mss_req = 0;
   endtask

   initial begin
      int t0, n, a2, nw2;
      repeat (3) @(negedge clk);
      chk("rst_ncs0", ncs0, 1); chk("rst_nwe", nwe, 1); chk("rst_doe", doe, 0);
      chk("rst_nbyte_en", nbe, 2'b11); chk("rst_rdata", mss_rdata, 0);
      rst = 0;
      @(negedge clk);
      run1(CAP, 1, 25'h0000123, 16'hBEEF, 2'b11);
      chk("t1_ack_cycle", r_ack, 5); chk("t1_ncs0_cycles", r_cs0, 5); chk("t1_nwe_cycles", r_nwe, 3);
      chk("t1_doe_cycles", r_doe, 5); chk("t1_dout", r_dout, 16'hBEEF); chk("t1_nbyte_en", r_nbe, 2'b00);
      chk("t1_ncs1_cycles", r_cs1, 0);
      @(negedge clk);
      chk("t1_ncs0_after", ncs0, 1); chk("t1_doe_after", doe, 0);
      din = 16'h5A5A;
      run1(MSS, 0, 25'h1000040, 16'h0000, 2'b11);
      chk("t2_ack_cycle", r_ack, 5); chk("t2_ncs1_cycles", r_cs1, 5); chk("t2_noe1_cycles", r_noe1, 3);
      chk("t2_ncs0_cycles", r_cs0, 0); chk("t2_noe0_cycles", r_noe0, 0); chk("t2_doe_cycles", r_doe, 0);
      chk("t2_nwe_cycles", r_nwe, 0); chk("t2_rdata", r_rdata, 16'h5A5A);
      din = 16'hFFFF;
      repeat (2) @(negedge clk);
      run1(MSS, 1, 25'h0000200, 16'h1234, 2'b10);
      chk("t4_ack_cycle", r_ack, 5); chk("t4_nbyte_en", r_nbe, 2'b01); chk("t4_cap_acks", r_other, 0);
      chk("t4_nwe_cycles", r_nwe, 3);
      run1(CAP, 1, 25'h0000321, 16'h7777, 2'b01);
      chk("t4_rdata_held", mss_rdata, 16'h5A5A);
      rst = 1;
      @(negedge clk);
      rst = 0;
      t0 = cyc;
      fork
         cap_seq(2, t0);
         mss_seq(2, t0);
      join
      chk("t3_cap_ack0", cap_acks[0], 5); chk("t3_mss_ack0", mss_acks[0], 11);
      chk("t3_cap_ack1", cap_acks[1], 17); chk("t3_mss_ack1", mss_acks[1], 23);
      @(negedge clk);
      cap_addr = 25'h0000010; cap_wdata = 16'hCAFE; cap_be = 2'b11; cap_req = 1;
      repeat (3) @(negedge clk);
      chk("t5_nwe_in_strobe", nwe, 0);
      rst = 1; cap_req = 0;
      @(negedge clk);
      chk("t5_nwe", nwe, 1); chk("t5_ncs0", ncs0, 1); chk("t5_doe", doe, 0); chk("t5_ack", cap_ack, 0);
      rst = 0;
      n = 0;
      repeat (8) begin @(negedge clk); n += cap_ack ? 1 : 0; end
      chk("t5_no_ack", n, 0);
      run1(CAP, 1, 25'h0000011, 16'h4321, 2'b11);
      chk("t5_fresh_ack", r_ack, 5); chk("t5_fresh_nwe", r_nwe, 3);
      a2 = -1; nw2 = 0;
      c2_req = 1;
      for (int k = 1; k <= 30 && a2 < 0; k++) begin
         @(negedge clk);
         nw2 += nwe2 ? 0 : 1;
         if (cap_ack2) begin a2 = k; c2_req = 0; end
      end
      c2_req = 0;
      chk("t6_ack_cycle", a2, 8); chk("t6_nwe_cycles", nw2, 4);
      repeat (3) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
